// File: rtl/wb_riot.sv
// Wishbone RIOT-style peripheral: up to two bidirectional I/O ports, an interval
// timer with 1/8/64/1024 prescale, and an edge detector on port 0's MSB.
module wb_riot #(
   parameter int NPORT = 2,
   parameter int DW    = 8,
   parameter int SYNC  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [6:0]            adr_i,
   input  logic [7:0]            dat_i,
   output logic                  ack_o,
   output logic [7:0]            dat_o,
   input  logic                  ready,
   input  logic [NPORT*DW-1:0]   port_i,
   output logic [NPORT*DW-1:0]   port_o,
   output logic [NPORT*DW-1:0]   port_oe,
   output logic                  irq_o
);

   typedef enum logic [1:0] {IVL_1, IVL_8, IVL_64, IVL_1024} ivl_e;

   logic [NPORT*DW-1:0]     sync_q [SYNC];
   logic [NPORT-1:0][DW-1:0] or_q, ddr_q, pin_s;
   logic [7:0]  intim_q;
   logic [10:0] presc_q;
   ivl_e        ivl_q;
   logic        fast_q, timint_q, edgeint_q, tim_ie_q, edge_ie_q, edge_rise_q, edge_prev_q;

   logic        accept, wr, rd, timer_load, edge_wr, intim_rd, flag_rd;
   logic        timer_tick, underflow, edge_msb, edge_evt;
   logic [10:0] ivl_last;
   logic [7:0]  rd_data;

   assign pin_s   = sync_q[SYNC-1];
   assign port_o  = or_q;
   assign port_oe = ddr_q;

   assign accept     = stb_i & ~ack_o;
   assign wr         = accept & we_i;
   assign rd         = accept & ~we_i;
   assign timer_load = wr & ((adr_i[6:2] == 5'b00101) | (adr_i[6:2] == 5'b00111));
   assign edge_wr    = wr & (adr_i[6:2] == 5'b00001);
   assign intim_rd   = rd & ((adr_i == 7'h04) | (adr_i == 7'h06));
   assign flag_rd    = rd & ((adr_i == 7'h05) | (adr_i == 7'h07));

   // After an underflow the timer free-runs at one count per tick until reloaded.
   always_comb begin
      ivl_last = 11'd1023;
      unique case (ivl_q)
         IVL_1:    ivl_last = 11'd0;
         IVL_8:    ivl_last = 11'd7;
         IVL_64:   ivl_last = 11'd63;
         IVL_1024: ivl_last = 11'd1023;
      endcase
      if (fast_q) ivl_last = 11'd0;
   end

   assign timer_tick = ready & ~timer_load & (presc_q == ivl_last);
   assign underflow  = timer_tick & (intim_q == 8'h00);
   assign edge_msb   = pin_s[0][DW-1];
   assign edge_evt   = edge_rise_q ? (edge_msb & ~edge_prev_q) : (~edge_msb & edge_prev_q);

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      rd_data = 8'h00;
      for (int n = 0; n < NPORT; n++) begin
         if (adr_i == 7'(2*n))
            rd_data[DW-1:0] = (or_q[n] & ddr_q[n]) | (pin_s[n] & ~ddr_q[n]);
         if (adr_i == 7'(2*n+1))
            rd_data[DW-1:0] = ddr_q[n];
      end
      case (adr_i)
         7'h04, 7'h06: rd_data = intim_q;
         7'h05, 7'h07: rd_data = {timint_q, edgeint_q, 6'b0};
         default: ;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the synchroniser is a small flop array, so it is reset like any other state.
         for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
         ack_o       <= 1'b0;
         dat_o       <= 8'h00;
         irq_o       <= 1'b0;
         or_q        <= '0;
         ddr_q       <= '0;
         intim_q     <= 8'h00;
         presc_q     <= 11'd0;
         ivl_q       <= IVL_1024;
         fast_q      <= 1'b0;
         timint_q    <= 1'b0;
         edgeint_q   <= 1'b0;
         tim_ie_q    <= 1'b0;
         edge_ie_q   <= 1'b0;
         edge_rise_q <= 1'b0;
         edge_prev_q <= 1'b0;
      end else begin
         ack_o <= accept;
         irq_o <= (timint_q & tim_ie_q) | (edgeint_q & edge_ie_q);

         sync_q[0] <= port_i;
         for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
         edge_prev_q <= edge_msb;

         if (accept) dat_o <= we_i ? 8'h00 : rd_data;

         if (wr) begin
            for (int n = 0; n < NPORT; n++) begin
               if (adr_i == 7'(2*n))   or_q[n]  <= dat_i[DW-1:0];
               if (adr_i == 7'(2*n+1)) ddr_q[n] <= dat_i[DW-1:0];
            end
         end

         if (edge_wr) begin
            edge_rise_q <= adr_i[0];
            edge_ie_q   <= adr_i[1];
         end

         if (edge_evt)     edgeint_q <= 1'b1;
         else if (flag_rd) edgeint_q <= 1'b0;

         if (timer_load) begin
            intim_q  <= dat_i;
            presc_q  <= 11'd0;
            ivl_q    <= ivl_e'(adr_i[1:0]);
            tim_ie_q <= adr_i[3];
            fast_q   <= 1'b0;
         end else if (ready) begin
            if (timer_tick) begin
               presc_q <= 11'd0;
               intim_q <= intim_q - 8'd1;
               if (underflow) fast_q <= 1'b1;
            end else begin
               presc_q <= presc_q + 11'd1;
            end
         end

         // Load beats underflow, underflow beats a clearing read.
         if (timer_load)     timint_q <= 1'b0;
         else if (underflow) timint_q <= 1'b1;
         else if (intim_rd)  timint_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_riot.sv
// Self-checking bench for wb_riot: vector table, hand-written timer/edge corner
// sequences, and a randomized run against a cycle-level behavioural model.
module tb_wb_riot;

   localparam int NPORT = 2;
   localparam int DW    = 8;
   localparam int SYNC  = 2;
   localparam int PW    = NPORT * DW;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          stb_i = 1'b0, we_i = 1'b0, ready = 1'b0;
   logic [6:0]    adr_i = '0;
   logic [7:0]    dat_i = '0;
   logic [PW-1:0] port_i = '0;
   logic          ack_o, irq_o;
   logic [7:0]    dat_o;
   logic [PW-1:0] port_o, port_oe;

   wb_riot #(.NPORT(NPORT), .DW(DW), .SYNC(SYNC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
      .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .ready(ready), .port_i(port_i),
      .port_o(port_o), .port_oe(port_oe), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;
   bit model_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: timer counts ready cycles against a period, pins seen SYNC cycles late.
   bit          m_ack, m_irq, m_fast, m_timint, m_edgeint, m_tie, m_eie, m_rise;
   logic [7:0]  m_dat;
   logic [7:0]  m_or [NPORT];
   logic [7:0]  m_ddr [NPORT];
   int          m_intim, m_cnt, m_period;
   logic [PW-1:0] pin_q [$];

   function automatic int period_of(input logic [1:0] code);
      case (code)
         2'd0:    return 1;
         2'd1:    return 8;
         2'd2:    return 64;
         default: return 1024;
      endcase
   endfunction

   task automatic model_step();
      logic [PW-1:0] s_now, s_prev;
      logic [7:0] rdv, pin_n;
      bit acc, rd_t, rd_f, load, uf, evt, nxt_irq;
      int a;
      if (rst_i) begin
         m_ack = 0; m_dat = 8'h00; m_irq = 0; m_fast = 0; m_timint = 0; m_edgeint = 0;
         m_tie = 0; m_eie = 0; m_rise = 0; m_intim = 0; m_cnt = 0; m_period = 1024;
         for (int n = 0; n < NPORT; n++) begin m_or[n] = 8'h00; m_ddr[n] = 8'h00; end
         pin_q.delete();
         repeat (SYNC + 1) pin_q.push_back('0);
         return;
      end
      a      = int'(adr_i);
      s_now  = pin_q[pin_q.size() - SYNC];
      s_prev = pin_q[pin_q.size() - 1 - SYNC];
      acc    = stb_i && !m_ack;
      rdv    = 8'h00;
      for (int n = 0; n < NPORT; n++) begin
         pin_n = s_now[n*DW +: DW];
         if (a == 2*n)   rdv = (m_or[n] & m_ddr[n]) | (pin_n & ~m_ddr[n]);
         if (a == 2*n+1) rdv = m_ddr[n];
      end
      if (a == 4 || a == 6) rdv = 8'(m_intim);
      if (a == 5 || a == 7) rdv = {m_timint, m_edgeint, 6'b0};
      nxt_irq = (m_timint && m_tie) || (m_edgeint && m_eie);
      evt  = m_rise ? (!s_prev[DW-1] && s_now[DW-1]) : (s_prev[DW-1] && !s_now[DW-1]);
      rd_t = acc && !we_i && (a == 4 || a == 6);
      rd_f = acc && !we_i && (a == 5 || a == 7);
      load = acc && we_i && ((a >= 'h14 && a <= 'h17) || (a >= 'h1C && a <= 'h1F));
      uf   = 0;
      if (load) begin
         m_intim = int'(dat_i); m_cnt = 0; m_period = period_of(adr_i[1:0]);
         m_tie = adr_i[3]; m_timint = 0; m_fast = 0;
      end else if (ready) begin
         m_cnt++;
         if (m_cnt >= (m_fast ? 1 : m_period)) begin
            m_cnt = 0;
            if (m_intim == 0) uf = 1;
            m_intim = (m_intim + 255) % 256;
         end
      end
      if (uf) begin m_timint = 1; m_fast = 1; end
      else if (rd_t) m_timint = 0;
      if (evt) m_edgeint = 1;
      else if (rd_f) m_edgeint = 0;
      if (acc && we_i && a >= 4 && a <= 7) begin m_rise = adr_i[0]; m_eie = adr_i[1]; end
      if (acc && we_i)
         for (int n = 0; n < NPORT; n++) begin
            if (a == 2*n)   m_or[n]  = dat_i;
            if (a == 2*n+1) m_ddr[n] = dat_i;
         end
      if (acc) m_dat = we_i ? 8'h00 : rdv;
      m_irq = nxt_irq;
      m_ack = acc;
      pin_q.push_back(port_i);
      if (pin_q.size() > SYNC + 2) void'(pin_q.pop_front());
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
      if (model_chk) begin
         check("rand_ack",     ack_o,   m_ack);
         check("rand_dat_o",   dat_o,   m_dat);
         check("rand_port_o",  port_o,  {m_or[1], m_or[0]});
         check("rand_port_oe", port_oe, {m_ddr[1], m_ddr[0]});
         check("rand_irq",     irq_o,   m_irq);
      end
   endtask

   task automatic run_ready(input int n);
      ready = 1'b1;
      repeat (n) tick();
      ready = 1'b0;
   endtask

   // One Wishbone access; rdy controls the ready input on the accept edge only.
   task automatic access(input bit w, input logic [6:0] a, input logic [7:0] d,
                         input bit rdy, output logic [7:0] q);
      stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d; ready = rdy;
      tick();
      check("ack_rise", ack_o, 1'b1);
      q = dat_o;
      stb_i = 1'b0; we_i = 1'b0; ready = 1'b0;
      tick();
      check("ack_fall", ack_o, 1'b0);
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      logic [7:0] q;
      access(1'b1, a, d, 1'b0, q);
   endtask

   task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
      logic [7:0] q;
      access(1'b0, a, 8'h00, 1'b0, q);
      check(name, q, exp);
   endtask

   task automatic do_reset();
      stb_i = 1'b0; we_i = 1'b0; ready = 1'b0; port_i = '0; rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
   endtask

   typedef struct {
      bit          we;
      logic [6:0]  adr;
      logic [7:0]  dat;
      logic [15:0] pins;
      logic [7:0]  exp_rd;
      logic [15:0] exp_po;
      logic [15:0] exp_oe;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit w, input logic [6:0] a, input logic [7:0] d, input logic [15:0] p,
                      input logic [7:0] r, input logic [15:0] po, input logic [15:0] oe);
      vecs.push_back('{w, a, d, p, r, po, oe});
   endtask

   initial begin
      logic [7:0] q;
      bit found;

      // Reset state and register/port behaviour
      add(0, 7'h00, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h01, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h02, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h03, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h04, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h05, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h06, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(0, 7'h07, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000);
      add(1, 7'h01, 8'hF0, 16'h0000, 8'h00, 16'h0000, 16'h00F0);
      add(1, 7'h00, 8'hA5, 16'h0000, 8'h00, 16'h00A5, 16'h00F0);
      add(0, 7'h00, 8'h00, 16'h003C, 8'hAC, 16'h00A5, 16'h00F0);
      add(1, 7'h03, 8'h0F, 16'h003C, 8'h00, 16'h00A5, 16'h0FF0);
      add(1, 7'h02, 8'h5A, 16'h003C, 8'h00, 16'h5AA5, 16'h0FF0);
      add(0, 7'h02, 8'h00, 16'h993C, 8'h9A, 16'h5AA5, 16'h0FF0);
      add(0, 7'h03, 8'h00, 16'h993C, 8'h0F, 16'h5AA5, 16'h0FF0);
      add(0, 7'h01, 8'h00, 16'h993C, 8'hF0, 16'h5AA5, 16'h0FF0);
      add(0, 7'h08, 8'h00, 16'h993C, 8'h00, 16'h5AA5, 16'h0FF0);
      add(0, 7'h7F, 8'h00, 16'h993C, 8'h00, 16'h5AA5, 16'h0FF0);
      add(0, 7'h44, 8'h00, 16'h993C, 8'h00, 16'h5AA5, 16'h0FF0);
      add(1, 7'h10, 8'hFF, 16'h993C, 8'h00, 16'h5AA5, 16'h0FF0);
      add(1, 7'h42, 8'hFF, 16'h993C, 8'h00, 16'h5AA5, 16'h0FF0);
      add(0, 7'h00, 8'h00, 16'h993C, 8'hAC, 16'h5AA5, 16'h0FF0);
      add(0, 7'h05, 8'h00, 16'h993C, 8'h00, 16'h5AA5, 16'h0FF0);

      do_reset();
      check("rst_ack",     ack_o,   1'b0);
      check("rst_dat_o",   dat_o,   8'h00);
      check("rst_irq",     irq_o,   1'b0);
      check("rst_port_o",  port_o,  16'h0000);
      check("rst_port_oe", port_oe, 16'h0000);

      foreach (vecs[i]) begin
         port_i = vecs[i].pins;
         repeat (3) tick();
         access(vecs[i].we, vecs[i].adr, vecs[i].dat, 1'b0, q);
         if (!vecs[i].we) check($sformatf("vec%0d_rd", i), q, vecs[i].exp_rd);
         check($sformatf("vec%0d_port_o", i),  port_o,  vecs[i].exp_po);
         check($sformatf("vec%0d_port_oe", i), port_oe, vecs[i].exp_oe);
      end
      check("table_irq", irq_o, 1'b0);

      // Reset during a pending write: ack drops, write discarded
      stb_i = 1'b1; we_i = 1'b1; adr_i = 7'h00; dat_i = 8'hFF; rst_i = 1'b1;
      tick();
      check("midrst_ack", ack_o, 1'b0);
      rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      tick();
      check("midrst_ack2",    ack_o,   1'b0);
      check("midrst_port_o",  port_o,  16'h0000);
      check("midrst_port_oe", port_oe, 16'h0000);

      // Timer at interval 8, no irq
      do_reset();
      wr(7'h15, 8'h03);
      run_ready(7);  rd_chk("t8_7",  7'h04, 8'h03);
      run_ready(1);  rd_chk("t8_8",  7'h04, 8'h02);
      run_ready(8);  rd_chk("t8_16", 7'h04, 8'h01);
      run_ready(8);  rd_chk("t8_24", 7'h04, 8'h00);
      run_ready(7);  rd_chk("t8_31", 7'h04, 8'h00);
      run_ready(1);
      rd_chk("t8_flags_uf", 7'h05, 8'h80);
      rd_chk("t8_32",       7'h04, 8'hFF);
      rd_chk("t8_flags_clr", 7'h05, 8'h00);
      run_ready(5);  rd_chk("t8_fast", 7'h04, 8'hFA);
      check("t8_irq", irq_o, 1'b0);

      // Timer at interval 1024 with irq
      do_reset();
      wr(7'h1F, 8'h01);
      run_ready(2047);
      check("t1k_irq_2047", irq_o, 1'b0);
      run_ready(1);
      check("t1k_irq_lag", irq_o, 1'b0);
      tick();
      check("t1k_irq_set", irq_o, 1'b1);
      rd_chk("t1k_intim", 7'h04, 8'hFF);
      check("t1k_irq_clr", irq_o, 1'b0);
      run_ready(3);
      rd_chk("t1k_fast", 7'h04, 8'hFC);
      rd_chk("t1k_flags", 7'h05, 8'h00);

      // Rising edge detect with irq, then falling edge without irq
      do_reset();
      wr(7'h07, 8'h00);
      port_i = 16'h0080;
      found = 1'b0;
      for (int i = 0; i < SYNC + 2 && !found; i++) begin
         tick();
         if (irq_o === 1'b1) found = 1'b1;
      end
      check("edge_irq_within", found, 1'b1);
      rd_chk("edge_flags", 7'h05, 8'h40);
      check("edge_irq_clr", irq_o, 1'b0);
      rd_chk("edge_flags2", 7'h05, 8'h00);
      wr(7'h04, 8'h00);
      port_i = 16'h0000;
      repeat (6) tick();
      check("fall_irq_off", irq_o, 1'b0);
      rd_chk("fall_flags", 7'h05, 8'h40);

      // Load in the same cycle as underflow; ready low freezes the timer
      do_reset();
      wr(7'h14, 8'h00);
      access(1'b1, 7'h14, 8'h55, 1'b1, q);
      rd_chk("ld_uf_flags", 7'h05, 8'h00);
      rd_chk("ld_uf_intim", 7'h04, 8'h55);
      repeat (100) tick();
      rd_chk("ready_low_intim", 7'h04, 8'h55);

      // Underflow beats the clearing INTIM read in the same cycle
      wr(7'h14, 8'h00);
      access(1'b0, 7'h04, 8'h00, 1'b1, q);
      check("uf_rd_val", q, 8'h00);
      rd_chk("uf_beats_clr", 7'h05, 8'h80);

      // Randomized run against the model
      do_reset();
      model_chk = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst_i = ($urandom_range(0, 399) == 0);
         stb_i = ($urandom_range(0, 2) == 0);
         we_i  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0, 1, 2, 3: adr_i = 7'($urandom_range(0, 7));
            4, 7:       adr_i = 7'(8'h14 + $urandom_range(0, 3));
            5:          adr_i = 7'(8'h1C + $urandom_range(0, 3));
            default:    adr_i = 7'($urandom);
         endcase
         dat_i = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) port_i = PW'($urandom);
         tick();
      end
      model_chk = 1'b0;
      rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
